mem_cfg_slave: RTL and testbench

MEM_CFG_SLAVE -- requirements
Module: mem_cfg_slave

---
 rtl/mem_cfg_slave.sv | 178 +++++++++++++++++
 tb/tb_mem_cfg_slave.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mem_cfg_slave.sv
// Memory-mapped configuration register slave: a 3-state FSM accepts one request,
// waits ACK_LAT cycles, then commits the write or returns read data with a one-cycle ack.
module mem_cfg_slave #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter int                NUM_REGS  = 4,
  parameter int                ACK_LAT   = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_sel_en,
  input  logic [ADDR_W-1:0]            mem_addr,
  input  logic [DATA_W-1:0]            mem_wr_data,
  input  logic                         mem_wr_rd_s,
  output logic [DATA_W-1:0]            mem_rd_data,
  output logic                         mem_ack,
  output logic                         mem_err,
  output logic [NUM_REGS*DATA_W-1:0]   cfg_regs,
  output logic [NUM_REGS-1:0]          cfg_wr_pulse
);

  localparam logic [3:0] CNT_LOAD = (ACK_LAT > 1) ? 4'(ACK_LAT - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2} state_t;

  state_t                      state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [DATA_W-1:0]           data_q, data_d;
  logic                        wr_q, wr_d;
  logic [NUM_REGS*DATA_W-1:0]  regs_q, regs_d;
  logic                        ack_q, ack_d;
  logic                        err_q, err_d;
  logic [DATA_W-1:0]           rd_q, rd_d;
  logic [NUM_REGS-1:0]         pulse_q, pulse_d;

  logic [ADDR_W-1:0]           acc_addr_s;
  logic [DATA_W-1:0]           acc_data_s;
  logic                        acc_wr_s;
  logic [NUM_REGS-1:0]         hit_s;
  logic [DATA_W-1:0]           rd_mux_s;
  logic                        in_range_s;
  logic                        enter_ack_s;

  // With ACK_LAT=1 the commit happens on the acceptance edge, so use live inputs in IDLE.
  always_comb begin
    if (state_q == IDLE) begin
      acc_addr_s = mem_addr;
      acc_data_s = mem_wr_data;
      acc_wr_s   = mem_wr_rd_s;
    end else begin
      acc_addr_s = addr_q;
      acc_data_s = data_q;
      acc_wr_s   = wr_q;
    end
  end

  // Full-width address decode; an address matching no register is out of range.
  always_comb begin
    hit_s    = {NUM_REGS{1'b0}};
    rd_mux_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (acc_addr_s == ADDR_W'(i)) begin
        hit_s[i] = 1'b1;
        rd_mux_s = regs_q[i*DATA_W +: DATA_W];
      end else begin
        hit_s[i] = 1'b0;
      end
    end
    in_range_s = |hit_s;
  end

  // Next-state, latency counter, and the register commit on entry to ACK.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wr_d        = wr_q;
    regs_d      = regs_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    rd_d        = {DATA_W{1'b0}};
    pulse_d     = {NUM_REGS{1'b0}};
    enter_ack_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_sel_en) begin
          addr_d = mem_addr;
          data_d = mem_wr_data;
          wr_d   = mem_wr_rd_s;
          if (ACK_LAT == 1) begin
            state_d     = ACK;
            enter_ack_s = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = ACK;
          enter_ack_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    if (enter_ack_s) begin
      ack_d = 1'b1;
      if (in_range_s) begin
        if (acc_wr_s) begin
          pulse_d = hit_s;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (hit_s[i]) begin
              regs_d[i*DATA_W +: DATA_W] = acc_data_s;
            end else begin
              regs_d[i*DATA_W +: DATA_W] = regs_q[i*DATA_W +: DATA_W];
            end
          end
        end else begin
          rd_d = rd_mux_s;
        end
      end else begin
        err_d = 1'b1;
      end
    end else begin
      ack_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= {ADDR_W{1'b0}};
      data_q  <= {DATA_W{1'b0}};
      wr_q    <= 1'b0;
      regs_q  <= {NUM_REGS{RESET_VAL}};
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= {DATA_W{1'b0}};
      pulse_q <= {NUM_REGS{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      regs_q  <= regs_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      pulse_q <= pulse_d;
    end
  end

  assign mem_ack      = ack_q;
  assign mem_err      = err_q;
  assign mem_rd_data  = rd_q;
  assign cfg_regs     = regs_q;
  assign cfg_wr_pulse = pulse_q;

endmodule

// File: tb/tb_mem_cfg_slave.sv
// Directed bench for mem_cfg_slave: ACK_LAT=2 instance for the main sequence,
// ACK_LAT=1 instance for back-to-back requests.
module tb_mem_cfg_slave;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        sel1;
  logic [7:0]  addr;
  logic [7:0]  wdata;
  logic        wr;
  logic [7:0]  rd_data, rd_data1;
  logic        ack, ack1;
  logic        err, err1;
  logic [31:0] regs, regs1;
  logic [3:0]  pulse, pulse1;

  int checks = 0;
  int errors = 0;

  mem_cfg_slave #(.ADDR_W(8), .DATA_W(8), .NUM_REGS(4), .ACK_LAT(2), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .mem_sel_en(sel), .mem_addr(addr), .mem_wr_data(wdata),
    .mem_wr_rd_s(wr), .mem_rd_data(rd_data), .mem_ack(ack), .mem_err(err),
    .cfg_regs(regs), .cfg_wr_pulse(pulse)
  );

  mem_cfg_slave #(.ADDR_W(8), .DATA_W(8), .NUM_REGS(4), .ACK_LAT(1), .RESET_VAL(8'h00)) dut1 (
    .clk(clk), .rst(rst), .mem_sel_en(sel1), .mem_addr(addr), .mem_wr_data(wdata),
    .mem_wr_rd_s(wr), .mem_rd_data(rd_data1), .mem_ack(ack1), .mem_err(err1),
    .cfg_regs(regs1), .cfg_wr_pulse(pulse1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One ACK_LAT=2 transaction; alt_addr/alt_data are driven during WAIT and must be ignored.
  task automatic txn(input logic is_wr, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] alt_a, input logic [7:0] alt_d,
                     input logic [31:0] exp_regs, input logic [7:0] exp_rd,
                     input logic exp_err, input logic [3:0] exp_pulse);
    @(negedge clk);
    sel = 1'b1; wr = is_wr; addr = a; wdata = d;
    @(negedge clk);
    chk("wait_ack", {31'd0, ack}, 32'd0);
    chk("wait_rd", {24'd0, rd_data}, 32'd0);
    sel = 1'b0; addr = alt_a; wdata = alt_d;
    @(negedge clk);
    chk("ack", {31'd0, ack}, 32'd1);
    chk("err", {31'd0, err}, {31'd0, exp_err});
    chk("rd_data", {24'd0, rd_data}, {24'd0, exp_rd});
    chk("regs", regs, exp_regs);
    chk("pulse", {28'd0, pulse}, {28'd0, exp_pulse});
    @(negedge clk);
    chk("post_ack", {31'd0, ack}, 32'd0);
    chk("post_rd", {24'd0, rd_data}, 32'd0);
    chk("post_err", {31'd0, err}, 32'd0);
    chk("post_pulse", {28'd0, pulse}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; sel1 = 1'b0; addr = 8'h00; wdata = 8'h00; wr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_regs", regs, 32'h0000_0000);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_pulse", {28'd0, pulse}, 32'd0);
    chk("rst_rd", {24'd0, rd_data}, 32'd0);
    rst = 1'b0;

    txn(1'b1, 8'h02, 8'hA5, 8'h02, 8'hA5, 32'h00A5_0000, 8'h00, 1'b0, 4'b0100);
    txn(1'b0, 8'h02, 8'h00, 8'h00, 8'h00, 32'h00A5_0000, 8'hA5, 1'b0, 4'b0000);
    txn(1'b1, 8'h07, 8'hFF, 8'h07, 8'hFF, 32'h00A5_0000, 8'h00, 1'b1, 4'b0000);
    txn(1'b0, 8'h07, 8'h00, 8'h07, 8'h00, 32'h00A5_0000, 8'h00, 1'b1, 4'b0000);
    txn(1'b1, 8'h01, 8'h3C, 8'h03, 8'hFF, 32'h00A5_3C00, 8'h00, 1'b0, 4'b0010);
    txn(1'b1, 8'h03, 8'h11, 8'h00, 8'h22, 32'h11A5_3C00, 8'h00, 1'b0, 4'b1000);
    txn(1'b1, 8'h04, 8'h77, 8'h00, 8'h77, 32'h11A5_3C00, 8'h00, 1'b1, 4'b0000);
    txn(1'b0, 8'hFF, 8'h00, 8'h03, 8'h00, 32'h11A5_3C00, 8'h00, 1'b1, 4'b0000);
    txn(1'b0, 8'h00, 8'h00, 8'h01, 8'h00, 32'h11A5_3C00, 8'h00, 1'b0, 4'b0000);
    txn(1'b0, 8'h03, 8'h00, 8'h02, 8'h00, 32'h11A5_3C00, 8'h11, 1'b0, 4'b0000);

    // Reset during WAIT of a write, with a request held during reset.
    @(negedge clk);
    sel = 1'b1; wr = 1'b1; addr = 8'h00; wdata = 8'h55;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ack", {31'd0, ack}, 32'd0);
    chk("abort_regs", regs, 32'h0000_0000);
    rst = 1'b0; sel = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_noack", {31'd0, ack}, 32'd0);
      chk("abort_noregs", regs, 32'h0000_0000);
      chk("abort_nopulse", {28'd0, pulse}, 32'd0);
    end

    // Three back-to-back reads on the ACK_LAT=1 instance.
    @(negedge clk);
    sel1 = 1'b1; wr = 1'b0; addr = 8'h01;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("b2b_ack", {31'd0, ack1}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("b2b_err", {31'd0, err1}, 32'd0);
      if (k == 5) sel1 = 1'b0;
    end
    @(negedge clk);
    chk("b2b_idle", {31'd0, ack1}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
